score_digits_display: RTL and testbench
=======================================

Name: score_digits_display

Overview:
- Upstream feeder of the number-bitmap drawer. Converts a binary score into decimal digits with a sequential double-dabble engine.
- For every VGA pixel it supplies the bitmap stage with the digit to draw, the pixel offset inside that digit's 16x32 cell, and an inside-rectangle flag.
- Sits between game logic (score counter) and the number-bitmap stage.
- The displayed digits change only when a conversion completes, so the score never tears mid-frame.

Parameters:
- TOP_LEFT_X, 11'd400, X of the left edge of the leftmost digit cell
- TOP_LEFT_Y, 11'd16, Y of the top edge of the digit row
- NUM_DIGITS, 4, number of decimal digits shown (fixed at 4 for this revision)
- DIGIT_GAP, 2, blank pixels between adjacent cells; cell pitch = 16 + DIGIT_GAP
- BLANK_LEADING, 1, 1 suppresses leading zeros (the least-significant digit is always shown)

Ports:
- clk  in  1  system pixel clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- scoreValue  in  14  binary score, sampled on load
- scoreLoad  in  1  one-cycle request to convert scoreValue
- offsetX  out  11  X offset inside the current digit cell, 0..15
- offsetY  out  11  Y offset inside the current digit cell, 0..31
- InsideRectangle  out  1  pixel lies in a visible, non-blanked digit cell
- digit  out  4  BCD digit for the current cell
- busy  out  1  conversion in progress
- convDone  out  1  one-cycle pulse when new digits are committed

Behaviour:
- Reset is asynchronous, active-low, on clk.
- Reset values:
  - offsetX = 0, offsetY = 0, InsideRectangle = 0, digit = 0, busy = 0, convDone = 0.
  - Committed digits = 0000. The display therefore shows "0" when BLANK_LEADING=1.
  - FSM returns to IDLE.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on scoreLoad, latch min(scoreValue, 9999) into the binary shift register, clear the BCD register, clear the count, go to SHIFT.
  - SHIFT: one bit per cycle. Every BCD nibble >= 5 gets +3, then the whole {bcd, bin} is shifted left by 1. After the 14th shift, go to COMMIT.
  - COMMIT: copy the BCD register into the committed digits, pulse convDone for 1 cycle, return to IDLE.
- Latency: scoreLoad sampled at edge k.
  - SHIFT runs on edges k+1..k+14.
  - Commit and convDone occur at edge k+15.
  - busy is high from edge k+1 through edge k+15.
- scoreLoad while busy: restart from the new value, following the same transition as in IDLE. The committed digits stay unchanged until the restarted conversion commits.
- scoreLoad in COMMIT: the commit still happens, and a new conversion starts on the same edge.
- scoreValue > 9999 (up to 16383): clamped to 9999 at load.
- Pixel path, registered with 1-cycle latency (outputs at edge n+1 reflect pixelX/pixelY at edge n):
  - relX = pixelX - TOP_LEFT_X, relY = pixelY - TOP_LEFT_Y, computed unsigned with an explicit "pixel >= top-left" check.
  - The pixel is in the row when relY < 32 and relX < NUM_DIGITS*pitch - DIGIT_GAP.
  - cell = relX / pitch, computed by comparator chain (no divider); col = relX - cell*pitch.
  - InsideRectangle = in-row AND col < 16 AND the cell is not blanked.
  - offsetX = col, offsetY = relY, digit = committed digit[cell]; cell 0 is the leftmost (thousands) digit.
  - Outside the row, or in a gap: InsideRectangle = 0, offsetX = offsetY = 0, digit = 0.
- Blanking, when BLANK_LEADING=1: a cell is blanked when it and all cells to its left are 0, except cell NUM_DIGITS-1, which is never blanked.
- Pixels left of or above the top-left corner never wrap into the row; the explicit >= check handles this.

Decomposition:
- Package score_display_pkg:
  - DIGIT_W=16, DIGIT_H=32, SCORE_W=14, SCORE_MAX=14'd9999.
  - typedef bcd_t (logic [3:0]).
  - typedef enum conv_state_t {IDLE, SHIFT, COMMIT}.
- Sub-module bin2bcd_seq: the FSM and double-dabble datapath with a load/busy/done interface and 16-bit BCD output.
- The top level holds the committed register, the blanking logic and the pixel-cell mapper.

Test Plan:
- Reset, then scan the row at TOP_LEFT_X=400, TOP_LEFT_Y=16 -> only cell 3 is inside; pixel (400+54+3, 20) gives InsideRectangle=1, offsetX=3, offsetY=4, digit=0 one cycle later.
- scoreLoad with scoreValue=1234 -> busy high for 15 cycles, convDone pulses exactly 15 edges after load. Then pixel (400+18+5, 26) gives digit=2, offsetX=5, offsetY=10, InsideRectangle=1.
- scoreValue=14000 -> committed 9999; all four cells show 9.
- scoreValue=7 with BLANK_LEADING=1 -> cells 0-2 give InsideRectangle=0 and cell 3 gives digit=7. Gap pixel (400+16, 20) gives InsideRectangle=0.
- Load 1234, then load 56 at SHIFT cycle 5 -> the display keeps its old value until one convDone at 15 edges after the second load, then shows 56. Exactly one convDone pulse in total.
- Assert resetN low mid-SHIFT -> busy=0, outputs zero, digits revert to 0000 immediately (asynchronously); a later load of 42 converts correctly.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types, constants and double-dabble helpers for the score digit display.
package score_display_pkg;

  localparam int DIGIT_W = 16;
  localparam int DIGIT_H = 32;
  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

endpackage

// File: rtl/score_digits_display_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, 14 shifts, then a commit strobe.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               load,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bcd
);

  conv_state_t        state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [15:0]        adj_s;

  // state and datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // next state; a load restarts from any state, including COMMIT
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj_s   = dabble_adjust(bcd_q);
    if (load) begin
      state_d = SHIFT;
      bin_d   = clamp_score(bin_in);
      bcd_d   = 16'd0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SHIFT: begin
          {bcd_d, bin_d} = {adj_s[14:0], bin_q, 1'b0};
          cnt_d          = cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_d = COMMIT;
          end else begin
            state_d = SHIFT;
          end
        end
        COMMIT: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    busy_d = (state_d != IDLE);
    busy   = busy_q;
    done   = (state_q == COMMIT);
    bcd    = bcd_q;
  end

endmodule

// File: rtl/score_digits_display.sv
// Score display feeder: commits converted digits and maps each pixel to a digit cell.
module score_digits_display
  import score_display_pkg::*;
#(
  parameter logic [10:0] TOP_LEFT_X    = 11'd400,
  parameter logic [10:0] TOP_LEFT_Y    = 11'd16,
  parameter int          NUM_DIGITS    = 4,
  parameter int          DIGIT_GAP     = 2,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic [SCORE_W-1:0] scoreValue,
  input  logic               scoreLoad,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic               InsideRectangle,
  output logic [3:0]         digit,
  output logic               busy,
  output logic               convDone
);

  localparam int          CELL_W = $clog2(NUM_DIGITS);
  localparam logic [10:0] PITCH  = 11'(DIGIT_W + DIGIT_GAP);
  localparam logic [10:0] ROW_W  = 11'(NUM_DIGITS * (DIGIT_W + DIGIT_GAP) - DIGIT_GAP);

  logic [15:0]       bcd_s;
  logic              done_s;
  logic [15:0]       committed_q, committed_d;
  logic              conv_done_q, conv_done_d;
  logic [10:0]       offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic              inside_q, inside_d;
  bcd_t              digit_q, digit_d;

  logic [10:0]       rel_x_s, rel_y_s, base_s, col_s;
  logic              in_row_s, lead_s;
  logic [CELL_W-1:0] cell_s;
  bcd_t              cell_digit_s;
  logic [NUM_DIGITS-1:0] blank_s;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .resetN (resetN),
    .load   (scoreLoad),
    .bin_in (scoreValue),
    .busy   (busy),
    .done   (done_s),
    .bcd    (bcd_s)
  );

  // committed digits and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      committed_q <= 16'd0;
      conv_done_q <= 1'b0;
      offset_x_q  <= 11'd0;
      offset_y_q  <= 11'd0;
      inside_q    <= 1'b0;
      digit_q     <= 4'd0;
    end else begin
      committed_q <= committed_d;
      conv_done_q <= conv_done_d;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
      inside_q    <= inside_d;
      digit_q     <= digit_d;
    end
  end

  // cell 0 is the leftmost (most significant) digit; comparator chain replaces relX / pitch
  always_comb begin
    committed_d = done_s ? bcd_s : committed_q;
    conv_done_d = done_s;
    rel_x_s     = pixelX - TOP_LEFT_X;
    rel_y_s     = pixelY - TOP_LEFT_Y;
    in_row_s    = (pixelX >= TOP_LEFT_X) && (pixelY >= TOP_LEFT_Y) &&
                  (rel_y_s < 11'(DIGIT_H)) && (rel_x_s < ROW_W);
    cell_s      = '0;
    base_s      = 11'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (rel_x_s >= 11'(i * (DIGIT_W + DIGIT_GAP))) begin
        cell_s = CELL_W'(i);
        base_s = 11'(i) * PITCH;
      end else begin
        cell_s = cell_s;
      end
    end
    col_s        = rel_x_s - base_s;
    lead_s       = 1'b1;
    cell_digit_s = 4'd0;
    blank_s      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_s = lead_s && (committed_q[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
      if (BLANK_LEADING && lead_s && (i != NUM_DIGITS - 1)) begin
        blank_s[i] = 1'b1;
      end else begin
        blank_s[i] = 1'b0;
      end
      if (cell_s == CELL_W'(i)) begin
        cell_digit_s = committed_q[(NUM_DIGITS-1-i)*4 +: 4];
      end else begin
        cell_digit_s = cell_digit_s;
      end
    end
    if (in_row_s && (col_s < 11'(DIGIT_W)) && !blank_s[cell_s]) begin
      inside_d   = 1'b1;
      offset_x_d = col_s;
      offset_y_d = rel_y_s;
      digit_d    = cell_digit_s;
    end else begin
      inside_d   = 1'b0;
      offset_x_d = 11'd0;
      offset_y_d = 11'd0;
      digit_d    = 4'd0;
    end
  end

  always_comb begin
    offsetX         = offset_x_q;
    offsetY         = offset_y_q;
    InsideRectangle = inside_q;
    digit           = digit_q;
    convDone        = conv_done_q;
  end

endmodule

// File: tb/tb_score_digits_display.sv
// Scoreboard bench: stimulus queues expected pixel responses and commit times; a monitor compares.
module tb_score_digits_display;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd0;
  logic [13:0] scoreValue = 14'd0;
  logic        scoreLoad = 1'b0;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle;
  logic [3:0]  digit;
  logic        busy, convDone;

  typedef struct {
    int          due;
    int          id;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [3:0]  dg;
  } pix_exp_t;

  pix_exp_t pix_q[$];
  int       conv_q[$];
  pix_exp_t e;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  int       pix_id = 0;
  int       due_c;

  score_digits_display dut (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .scoreValue      (scoreValue),
    .scoreLoad       (scoreLoad),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .digit           (digit),
    .busy            (busy),
    .convDone        (convDone)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // monitor: pixel responses by due cycle, commit pulses by arrival
  initial forever begin
    @(negedge clk);
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      e = pix_q.pop_front();
      checks++;
      if (InsideRectangle !== e.ins || offsetX !== e.ox || offsetY !== e.oy || digit !== e.dg) begin
        errors++;
        $display("FAIL pix%0d: got ins=%0b ox=%0d oy=%0d dig=%0d, want ins=%0b ox=%0d oy=%0d dig=%0d",
                 e.id, InsideRectangle, offsetX, offsetY, digit, e.ins, e.ox, e.oy, e.dg);
      end
    end
    if (resetN && convDone === 1'b1) begin
      checks++;
      if (conv_q.size() == 0) begin
        errors++;
        $display("FAIL conv_done: unexpected pulse at cycle %0d", cyc);
      end else begin
        due_c = conv_q.pop_front();
        if (due_c != cyc) begin
          errors++;
          $display("FAIL conv_done: pulse at cycle %0d, want %0d", cyc, due_c);
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input logic ins, input int ox, input int oy, input int dg);
    pix_exp_t p;
    @(posedge clk);
    #1;
    pixelX = 11'(x);
    pixelY = 11'(y);
    pix_id++;
    p.due = cyc + 1;
    p.id  = pix_id;
    p.ins = ins;
    p.ox  = 11'(ox);
    p.oy  = 11'(oy);
    p.dg  = 4'(dg);
    pix_q.push_back(p);
  endtask

  task automatic load(input int v, input bit expect_commit);
    @(posedge clk);
    #1;
    scoreValue = 14'(v);
    scoreLoad  = 1'b1;
    if (expect_commit) conv_q.push_back(cyc + 16);
    @(posedge clk);
    #1;
    scoreLoad = 1'b0;
  endtask

  task automatic busy_len();
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, want 15", n);
    end
  endtask

  task automatic wait_conv();
    for (int i = 0; i < 40; i++) begin
      if (conv_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (conv_q.size() != 0) begin
      errors++;
      $display("FAIL conv_timeout: %0d commits outstanding, want 0", conv_q.size());
      conv_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0 ||
        digit !== 4'd0 || busy !== 1'b0 || convDone !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ins=%0b ox=%0d oy=%0d dig=%0d busy=%0b done=%0b, want all 0",
               name, InsideRectangle, offsetX, offsetY, digit, busy, convDone);
    end
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(posedge clk);
    #3 resetN = 1'b1;

    // display "0": only cell 3 visible
    pix(457, 20, 1'b1, 3, 4, 0);
    pix(400, 20, 1'b0, 0, 0, 0);
    pix(399, 20, 1'b0, 0, 0, 0);
    pix(400, 15, 1'b0, 0, 0, 0);
    pix(470, 20, 1'b0, 0, 0, 0);
    pix(469, 47, 1'b1, 15, 31, 0);
    pix(457, 48, 1'b0, 0, 0, 0);

    load(1234, 1'b1);
    busy_len();
    pix(423, 26, 1'b1, 5, 10, 2);
    pix(416, 20, 1'b0, 0, 0, 0);
    pix(400, 16, 1'b1, 0, 0, 1);
    pix(443, 17, 1'b1, 7, 1, 3);
    pix(454, 30, 1'b1, 0, 14, 4);

    load(14000, 1'b1);
    wait_conv();
    pix(400, 16, 1'b1, 0, 0, 9);
    pix(418, 16, 1'b1, 0, 0, 9);
    pix(436, 16, 1'b1, 0, 0, 9);
    pix(454, 16, 1'b1, 0, 0, 9);

    load(7, 1'b1);
    wait_conv();
    pix(400, 16, 1'b0, 0, 0, 0);
    pix(418, 16, 1'b0, 0, 0, 0);
    pix(436, 16, 1'b0, 0, 0, 0);
    pix(455, 17, 1'b1, 1, 1, 7);
    pix(416, 20, 1'b0, 0, 0, 0);

    // restart mid-conversion: old digits persist, single commit
    load(1234, 1'b0);
    pix(454, 16, 1'b1, 0, 0, 7);
    pix(454, 16, 1'b1, 0, 0, 7);
    pix(454, 16, 1'b1, 0, 0, 7);
    load(56, 1'b1);
    pix(454, 16, 1'b1, 0, 0, 7);
    pix(436, 16, 1'b0, 0, 0, 0);
    wait_conv();
    pix(436, 16, 1'b1, 0, 0, 5);
    pix(418, 16, 1'b0, 0, 0, 0);
    pix(454, 16, 1'b1, 0, 0, 6);

    // asynchronous reset in the middle of a conversion
    load(1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 resetN = 1'b0;
    #1 check_zero("reset_mid_shift");
    @(posedge clk);
    #3 resetN = 1'b1;
    pix(454, 16, 1'b1, 0, 0, 0);
    pix(436, 16, 1'b0, 0, 0, 0);

    load(42, 1'b1);
    wait_conv();
    pix(436, 16, 1'b1, 0, 0, 4);
    pix(454, 16, 1'b1, 0, 0, 2);
    pix(418, 16, 1'b0, 0, 0, 0);

    repeat (4) @(posedge clk);
    checks++;
    if (pix_q.size() != 0) begin
      errors++;
      $display("FAIL pix_drain: %0d responses unchecked, want 0", pix_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
